decimal_to_bin: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble (shift-right / subtract-3).
- Counterpart of the scoreboard's binary-to-decimal path. Turns a packed BCD value (e.g. tens/ones from a digit-entry or preset path) back into a binary score for the counter logic.
- Uses a start/busy/done handshake and flags malformed BCD digits.

---
 rtl/decimal_to_bin_if.sv | 30 +++
 rtl/decimal_to_bin.sv | 115 +++++++++++
 tb/tb_decimal_to_bin.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decimal_to_bin_if.sv
// Start/busy/done handshake and result bundle for the BCD-to-binary converter.
interface decimal_to_bin_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  start_i;
    logic [4*DIGITS-1:0]   bcd_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
    logic [BIN_W-1:0]      bin_o;

    modport master (
        output start_i,
        output bcd_i,
        input  busy_o,
        input  done_o,
        input  err_o,
        input  bin_o
    );

    modport slave (
        input  start_i,
        input  bcd_i,
        output busy_o,
        output done_o,
        output err_o,
        output bin_o
    );
endinterface

// File: rtl/decimal_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One shift/correct iteration per clock; malformed digits short-cut to DONE.
module decimal_to_bin #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    decimal_to_bin_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SR_W-1:0]    step;
    logic               bad_digit;

    // Shift the {bcd, bin} register right, then pull any digit >= 8 down by 3.
    always_comb begin
        step = sr_q >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (step[BIN_W+4*i +: 4] >= 4'd8) begin
                step[BIN_W+4*i +: 4] = step[BIN_W+4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_i[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    sr_d  = {bus.bcd_i, {BIN_W{1'b0}}};
                    cnt_d = '0;
                    if (bad_digit) begin
                        state_d = DONE;
                        bin_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                sr_d  = step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                    bin_d   = step[BIN_W-1:0];
                    err_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CONVERT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.err_o  = err_q;
    assign bus.bin_o  = bin_q;
endmodule

// File: tb/tb_decimal_to_bin.sv
// Randomized self-checking bench for decimal_to_bin.
module tb_decimal_to_bin;
    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;
    localparam int LAT    = BIN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    decimal_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    decimal_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int model_val(input logic [7:0] b);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic bit model_err(input logic [7:0] b);
        bit e = 0;
        for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) e = 1;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion from IDLE and reports what was observed.
    task automatic do_conv(input logic [7:0] b, output int lat, output int nbusy,
                           output logic [6:0] rbin, output logic rerr,
                           output bit chg, output logic dn_next);
        logic [6:0] prev;
        prev = bus.bin_o;
        bus.start_i = 1'b1;
        bus.bcd_i   = b;
        step();
        bus.start_i = 1'b0;
        bus.bcd_i   = 8'($urandom);
        lat = 0; nbusy = 0; chg = 0;
        while (!bus.done_o && lat < 40) begin
            if (bus.busy_o) nbusy++;
            if (bus.bin_o !== prev) chg = 1;
            step();
            lat++;
        end
        rbin = bus.bin_o;
        rerr = bus.err_o;
        step();
        dn_next = bus.done_o;
    endtask

    task automatic check_conv(input string nm, input logic [7:0] b);
        int lat, nb, ev, el;
        logic [6:0] rb;
        logic re, dn;
        bit chg, ee;
        do_conv(b, lat, nb, rb, re, chg, dn);
        ee = model_err(b);
        ev = ee ? 0 : model_val(b);
        el = ee ? 0 : LAT;
        n_cmp++;
        if (lat !== el) begin
            n_bad++;
            $display("FAIL %s latency bcd=%h got %0d want %0d", nm, b, lat, el);
        end
        n_cmp++;
        if (rb !== 7'(ev)) begin
            n_bad++;
            $display("FAIL %s bin bcd=%h got %0d want %0d", nm, b, rb, ev);
        end
        n_cmp++;
        if (re !== ee) begin
            n_bad++;
            $display("FAIL %s err bcd=%h got %b want %b", nm, b, re, ee);
        end
        n_cmp++;
        if (nb !== el) begin
            n_bad++;
            $display("FAIL %s busy_cycles bcd=%h got %0d want %0d", nm, b, nb, el);
        end
        n_cmp++;
        if (chg !== 1'b0 || dn !== 1'b0) begin
            n_bad++;
            $display("FAIL %s early_change/done_width got %b/%b want 0/0", nm, chg, dn);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.busy_o, bus.done_o, bus.err_o, bus.bin_o} !== '0) begin
            n_bad++;
            $display("FAIL reset outputs got %b%b%b %0d want 0000",
                     bus.busy_o, bus.done_o, bus.err_o, bus.bin_o);
        end
    endtask

    task automatic test_basic();
        check_conv("basic42", 8'h42);
    endtask

    task automatic test_corners();
        logic [7:0] tbl [4] = '{8'h00, 8'h99, 8'h09, 8'h10};
        foreach (tbl[i]) check_conv("corner", tbl[i]);
    endtask

    task automatic test_invalid();
        check_conv("invalidA3", 8'hA3);
        check_conv("after_err15", 8'h15);
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [6:0] rb = '0;
        bus.start_i = 1'b1;
        bus.bcd_i   = 8'h37;
        step();
        bus.start_i = 1'b0;
        step();
        step();
        bus.start_i = 1'b1;
        bus.bcd_i   = 8'h88;
        step();
        bus.start_i = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (bus.done_o) begin
                dones++;
                rb = bus.bin_o;
            end
            step();
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL ignore_start done_count got %0d want 1", dones);
        end
        n_cmp++;
        if (rb !== 7'(model_val(8'h37))) begin
            n_bad++;
            $display("FAIL ignore_start bin got %0d want 37", rb);
        end
    endtask

    task automatic test_back_to_back();
        bit d_a [32];
        bit b_a [32];
        int nd = 0;
        bus.start_i = 1'b1;
        bus.bcd_i   = 8'h58;
        for (int k = 0; k < 32; k++) begin
            step();
            d_a[k] = bus.done_o;
            b_a[k] = bus.busy_o;
            if (bus.done_o) begin
                nd++;
                n_cmp++;
                if (bus.bin_o !== 7'(58)) begin
                    n_bad++;
                    $display("FAIL b2b bin got %0d want 58", bus.bin_o);
                end
            end
        end
        bus.start_i = 1'b0;
        n_cmp++;
        if (nd < 2) begin
            n_bad++;
            $display("FAIL b2b done_count got %0d want >=2", nd);
        end
        for (int k = 0; k + 2 < 32; k++) begin
            if (d_a[k]) begin
                n_cmp++;
                if (b_a[k+1] !== 1'b0 || b_a[k+2] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b gap at %0d got busy %b%b want 01",
                             k, b_a[k+1], b_a[k+2]);
                end
            end
        end
        for (int k = 0; k < 12; k++) step();
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        bus.start_i = 1'b1;
        bus.bcd_i   = 8'h64;
        step();
        bus.start_i = 1'b0;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy_o, bus.done_o, bus.err_o, bus.bin_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid outputs got %b%b%b %0d want 0000",
                     bus.busy_o, bus.done_o, bus.err_o, bus.bin_o);
        end
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done_o) dones++;
            step();
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL reset_mid spurious_done got %0d want 0", dones);
        end
        check_conv("after_rst64", 8'h64);
    endtask

    task automatic test_hold();
        int bad = 0;
        check_conv("hold42", 8'h42);
        for (int k = 0; k < 20; k++) begin
            bus.bcd_i = 8'($urandom);
            step();
            if (bus.bin_o !== 7'(42) || bus.done_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL hold bad_cycles got %0d want 0 (bin %0d)", bad, bus.bin_o);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int k = 0; k < 40; k++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                b[3:0] = 4'($urandom_range(0, 9));
                b[7:4] = 4'($urandom_range(0, 9));
            end
            check_conv("random", b);
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.bcd_i   = '0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_reset();
        test_basic();
        test_corners();
        test_invalid();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
